// File: rtl/valid_stream_receiver.sv
// ============================================================================
// Module      : valid_stream_receiver
// Description : Valid-only stream to AXI-Stream bridge. Incoming beats are
//               buffered in a DEPTH-entry FWFT FIFO; beats arriving while
//               full are dropped and flagged. Define RX_DROP_COUNT_EN to
//               build the saturating dropped-beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module valid_stream_receiver #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       overflow_clr,
    output logic [15:0]                drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] C_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] level_after_pop;
    logic [WIDTH-1:0] tdata_q, tdata_d;
    logic             tvalid_q;
    logic             overflow_q;
    logic             push, pop, drop;

    assign pop  = tvalid_q & m_axis_tready;
    assign push = in_valid & ~rst & ((level_q != C_FULL) | pop);
    assign drop = in_valid & ~rst & ~push;

    assign level_after_pop = level_q - LVL_W'(pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        tdata_d  = tdata_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        // Next head: the beat being written now if nothing older remains,
        // otherwise the entry the read pointer lands on.
        if (level_after_pop != '0)
            tdata_d = mem_q[rd_ptr_d];
        else if (push)
            tdata_d = in_data;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tdata_q  <= tdata_d;
            tvalid_q <= (level_d != '0);
            if (drop)
                overflow_q <= 1'b1;
            else if (overflow_clr)
                overflow_q <= 1'b0;
        end
    end

`ifdef RX_DROP_COUNT_EN
    logic [15:0] drop_count_q;

    always_ff @(posedge clk) begin
        if (rst)
            drop_count_q <= '0;
        else if (overflow_clr)
            drop_count_q <= drop ? 16'd1 : 16'd0;
        else if (drop && drop_count_q != 16'hFFFF)
            drop_count_q <= drop_count_q + 16'd1;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 16'd0;
`endif

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign level         = level_q;
    assign overflow      = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_valid_stream_receiver.sv
// ============================================================================
// Module      : tb_valid_stream_receiver
// Description : Scoreboard bench for valid_stream_receiver: directed scenarios
//               followed by random traffic, checked against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_valid_stream_receiver;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             overflow_clr;
    logic [15:0]      drop_count;

    valid_stream_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: the FIFO contents as a plain queue plus flag/counter.
    logic [WIDTH-1:0] exp_q [$];
    bit               exp_ov = 1'b0;
    int               exp_dc = 0;
    bit               expect_zero = 1'b0;
    bit               stall_prev = 1'b0;
    logic [WIDTH-1:0] stall_data = '0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs and inputs are both settled at the falling edge; the
    // model first compares what the DUT shows, then applies the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            int  sz;
            bit  pop, full, drop;
            sz = exp_q.size();
            check("level", longint'(level), longint'(sz));
            check("tvalid", longint'(m_axis_tvalid), longint'(sz != 0));
            check("overflow", longint'(overflow), longint'(exp_ov));
`ifdef RX_DROP_COUNT_EN
            check("drop_count", longint'(drop_count), longint'(exp_dc));
`else
            check("drop_count", longint'(drop_count), 0);
`endif
            if (expect_zero)
                check("tdata_reset", longint'(m_axis_tdata), 0);
            if (stall_prev && sz != 0)
                check("tdata_stable", longint'(m_axis_tdata), longint'(stall_data));

            if (rst) begin
                exp_q.delete();
                exp_ov      = 1'b0;
                exp_dc      = 0;
                expect_zero = 1'b1;
                stall_prev  = 1'b0;
            end else begin
                expect_zero = 1'b0;
                pop  = (sz != 0) && m_axis_tready;
                full = (sz == DEPTH);
                if (pop) begin
                    check("tdata_pop", longint'(m_axis_tdata), longint'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                stall_prev = (sz != 0) && !m_axis_tready;
                stall_data = m_axis_tdata;
                drop = in_valid && full && !pop;
                if (in_valid && !drop)
                    exp_q.push_back(in_data);
                if (drop)
                    exp_ov = 1'b1;
                else if (overflow_clr)
                    exp_ov = 1'b0;
                if (overflow_clr)
                    exp_dc = drop ? 1 : 0;
                else if (drop && exp_dc != 16'hFFFF)
                    exp_dc = exp_dc + 1;
            end
        end
    end

    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit rdy,
                         input bit clr = 1'b0, input bit r = 1'b0);
        in_valid      = v;
        in_data       = d;
        m_axis_tready = rdy;
        overflow_clr  = clr;
        rst           = r;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, '0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        m_axis_tready = 1'b0; overflow_clr = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        // Reset held with in_valid asserted
        drive(1'b1, 32'hCAFE_0001, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'hCAFE_0002, 1'b1, 1'b0, 1'b1);

        // Passthrough
        drive(1'b1, 32'h11, 1'b1);
        drive(1'b1, 32'h22, 1'b1);
        drive(1'b1, 32'h33, 1'b1);
        drain();

        // Fill past full with no readiness, then drain in order
        for (int i = 0; i < 20; i++) drive(1'b1, WIDTH'(i), 1'b0);
        drive(1'b0, '0, 1'b0);
        drain();

        // Full with concurrent push and pop
        drive(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b1, WIDTH'(32'h100 + i), 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, WIDTH'(32'h200 + i), 1'b1);
        drain();

        // Backpressure: tready toggling while the stream continues
        for (int i = 0; i < 4; i++) drive(1'b1, WIDTH'(32'h300 + i), 1'b0);
        for (int i = 0; i < 10; i++) drive(i < 5, WIDTH'(32'h400 + i), i[0]);
        drain();

        // Drop coinciding with overflow_clr, then reset at level 7
        for (int i = 0; i < DEPTH; i++) drive(1'b1, WIDTH'(32'h500 + i), 1'b0);
        drive(1'b1, 32'h5FF, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b1, WIDTH'(32'h600 + i), 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b1);

        // Random traffic with occasional clears and resets
        for (int i = 0; i < 4000; i++) begin
            int phase;
            phase = (i / 200) % 3;
            drive(($urandom_range(99) < (phase == 0 ? 90 : 50)),
                  WIDTH'($urandom),
                  ($urandom_range(99) < (phase == 1 ? 90 : 30)),
                  ($urandom_range(99) < 3),
                  ($urandom_range(999) < 2));
        end
        drain();

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
